// File: rtl/tcb_sub_mem.sv
// tcb_sub_mem: TCB subordinate byte-enabled memory with wait states and fixed response delay (define TCB_SUB_MEM_ERR_EN for out-of-range error responses)
module tcb_sub_mem #(
  parameter int ADR  = 32,
  parameter int DAT  = 32,
  parameter int SIZ  = 4096,
  parameter int DLY  = 1,
  parameter int WAIT = 0
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             tcb_vld,
  output logic             tcb_rdy,
  input  logic             tcb_req_wen,
  input  logic [ADR-1:0]   tcb_req_adr,
  input  logic [DAT/8-1:0] tcb_req_ben,
  input  logic [DAT-1:0]   tcb_req_wdt,
  output logic [DAT-1:0]   tcb_rsp_rdt,
  output logic             tcb_rsp_err
);
  localparam int BEN = DAT/8;
  localparam int ALB = $clog2(BEN);
  localparam int AMB = $clog2(SIZ);
  localparam int WRD = SIZ/BEN;
  localparam logic [3:0] WT = 4'(WAIT);
  typedef enum logic {IDLE, STALL} state_t;
  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic trn, oor, unused_adr;
  logic [AMB-ALB-1:0] idx;
  logic [DAT-1:0] mem [WRD];
  logic [DAT-1:0] rdt_q [DLY];
  assign trn = tcb_vld & tcb_rdy;
  assign idx = tcb_req_adr[AMB-1:ALB];
  assign unused_adr = ^tcb_req_adr;
  assign tcb_rsp_rdt = rdt_q[DLY-1];
  // wait-state register; reset drops any stall in progress
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
    end
  // ready is held low during reset so no transfer (and no write) can happen then
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt;
    tcb_rdy = 1'b0;
    case (state)
      IDLE: begin
        tcb_rdy = rst && (WAIT == 0);
        if (tcb_vld && WAIT != 0) begin
          state_nxt = STALL;
          cnt_nxt = 4'd1;
        end
      end
      STALL: begin
        tcb_rdy = rst && (cnt == WT);
        if (!tcb_vld || cnt == WT) begin
          state_nxt = IDLE;
          cnt_nxt = '0;
        end else cnt_nxt = cnt + 4'd1;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt = '0;
      end
    endcase
  end
  // byte-enabled write committed at the end of the transfer cycle
  always_ff @(posedge clk)
    if (trn && tcb_req_wen && !oor)
      for (int b = 0; b < BEN; b++)
        if (tcb_req_ben[b]) mem[idx][8*b +: 8] <= tcb_req_wdt[8*b +: 8];
  // first stage captures read data on transfer, later stages shift every cycle
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int i = 0; i < DLY; i++) rdt_q[i] <= '0;
    end else begin
      if (trn) rdt_q[0] <= (tcb_req_wen || oor) ? '0 : mem[idx];
      for (int i = 1; i < DLY; i++) rdt_q[i] <= rdt_q[i-1];
    end
`ifdef TCB_SUB_MEM_ERR_EN
  logic err_q [DLY];
  assign oor = |tcb_req_adr[ADR-1:AMB];
  assign tcb_rsp_err = err_q[DLY-1];
  // error flag travels alongside the read data
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int i = 0; i < DLY; i++) err_q[i] <= 1'b0;
    end else begin
      if (trn) err_q[0] <= oor;
      for (int i = 1; i < DLY; i++) err_q[i] <= err_q[i-1];
    end
`else
  assign oor = 1'b0;
  assign tcb_rsp_err = 1'b0;
`endif
endmodule

// File: tb/tb_tcb_sub_mem.sv
// tb_tcb_sub_mem: randomized self-checking bench for tcb_sub_mem against a transfer-level model
module tb_tcb_sub_mem;
  localparam int NI = 3;
  localparam int WT [NI] = '{0, 3, 5};
  localparam int DL [NI] = '{1, 3, 2};
  typedef struct {bit idle; bit w; logic [31:0] a; logic [3:0] b; logic [31:0] d;} req_t;
  typedef struct {int due; logic [31:0] r; logic e;} rsp_t;
  logic clk = 1'b0, rst = 1'b1;
  logic vld [NI], rdy [NI], wen [NI], err [NI], tr [NI];
  logic [31:0] adr [NI], wdt [NI], rdt [NI];
  logic [3:0] ben [NI];
  req_t rqq [NI][$];
  rsp_t rsq [NI][$];
  req_t cur [NI];
  logic [31:0] mm [NI][1024];
  logic [31:0] cur_rdt [NI];
  logic cur_err [NI];
  int wt [NI];
  int cyc = 0, nvec = 0, nerr = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < NI; g++) begin : g_dut
    tcb_sub_mem #(.ADR(32), .DAT(32), .SIZ(4096), .DLY(DL[g]), .WAIT(WT[g])) u_dut (
      .clk(clk), .rst(rst), .tcb_vld(vld[g]), .tcb_rdy(rdy[g]),
      .tcb_req_wen(wen[g]), .tcb_req_adr(adr[g]), .tcb_req_ben(ben[g]), .tcb_req_wdt(wdt[g]),
      .tcb_rsp_rdt(rdt[g]), .tcb_rsp_err(err[g]));
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask
  task automatic push(input int k, input bit idle, input bit w, input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
    req_t q;
    q.idle = idle; q.w = w; q.a = a; q.b = b; q.d = d;
    rqq[k].push_back(q);
  endtask
  task automatic load(input int k);
    vld[k] = 1'b0;
    if (rqq[k].size() == 0) return;
    cur[k] = rqq[k].pop_front();
    if (cur[k].idle) return;
    vld[k] = 1'b1; wen[k] = cur[k].w; adr[k] = cur[k].a; ben[k] = cur[k].b; wdt[k] = cur[k].d;
  endtask
  task automatic xfer(input int k);
    logic [9:0] i;
    logic [31:0] m, r;
    logic o;
    i = cur[k].a[11:2];
    o = 1'b0;
    r = '0;
`ifdef TCB_SUB_MEM_ERR_EN
    o = cur[k].a[31:12] != 0;
`endif
    m = {{8{cur[k].b[3]}}, {8{cur[k].b[2]}}, {8{cur[k].b[1]}}, {8{cur[k].b[0]}}};
    if (cur[k].w && !o) mm[k][i] = (mm[k][i] & ~m) | (cur[k].d & m);
    if (!cur[k].w && !o) r = mm[k][i];
    rsq[k].push_back('{cyc + DL[k] - 1, r, o});
  endtask
  task automatic step();
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      while (rsq[k].size() != 0 && rsq[k][0].due <= cyc) begin
        cur_rdt[k] = rsq[k][0].r;
        cur_err[k] = rsq[k][0].e;
        void'(rsq[k].pop_front());
      end
      chk($sformatf("rdy%0d", k), 64'(rdy[k]), 64'(wt[k] == WT[k]));
      chk($sformatf("rdt%0d", k), 64'(rdt[k]), 64'(cur_rdt[k]));
      chk($sformatf("err%0d", k), 64'(err[k]), 64'(cur_err[k]));
      tr[k] = vld[k] && wt[k] == WT[k];
    end
    @(posedge clk);
    cyc++;
    #1;
    for (int k = 0; k < NI; k++) begin
      if (tr[k]) begin
        xfer(k);
        wt[k] = 0;
        load(k);
      end else if (vld[k]) wt[k]++;
      else begin
        wt[k] = 0;
        load(k);
      end
    end
  endtask
  task automatic do_reset(input int n);
    rst = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("rst_rdy%0d", k), 64'(rdy[k]), 64'(0));
      chk($sformatf("rst_rdt%0d", k), 64'(rdt[k]), 64'(0));
      chk($sformatf("rst_err%0d", k), 64'(err[k]), 64'(0));
      rsq[k].delete();
      cur_rdt[k] = '0;
      cur_err[k] = 1'b0;
      wt[k] = 0;
    end
    repeat (n) @(posedge clk);
    #1 rst = 1'b1;
  endtask
  function automatic bit busy();
    for (int k = 0; k < NI; k++) if (vld[k] || rqq[k].size() != 0) return 1'b1;
    return 1'b0;
  endfunction
  task automatic run();
    int n = 0;
    for (int k = 0; k < NI; k++) if (!vld[k]) load(k);
    while (busy() && n < 5000) begin
      step();
      n++;
    end
    if (busy()) begin
      nvec++;
      nerr++;
      $display("FAIL timeout: requests still pending after %0d cycles", n);
    end
    repeat (6) step();
  endtask
  initial begin
    for (int k = 0; k < NI; k++) begin
      vld[k] = 1'b0; wen[k] = 1'b0; adr[k] = '0; ben[k] = '0; wdt[k] = '0;
      wt[k] = 0; cur_rdt[k] = '0; cur_err[k] = 1'b0; tr[k] = 1'b0;
    end
    #2 do_reset(2);
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < 16; i++) push(k, 0, 1, 32'(i * 4), 4'hF, $urandom);
      push(k, 0, 1, 32'h10, 4'hF, 32'hDEADBEEF);
      push(k, 0, 1, 32'h10, 4'h3, 32'h12345678);
      push(k, 0, 0, 32'h10, 4'h0, 32'h0);
      push(k, 0, 0, 32'h0, 4'hF, 32'h0);
      push(k, 0, 0, 32'h4, 4'hF, 32'h0);
      push(k, 0, 0, 32'h8, 4'hF, 32'h0);
      push(k, 1, 0, 32'h0, 4'h0, 32'h0);
      push(k, 0, 1, 32'h20, 4'h0, 32'hFFFFFFFF);
      push(k, 0, 0, 32'h20, 4'h0, 32'h0);
      push(k, 0, 0, 32'h1000, 4'hF, 32'h0);
      push(k, 0, 1, 32'h1004, 4'hF, 32'hCAFEF00D);
      push(k, 0, 0, 32'h4, 4'hF, 32'h0);
    end
    run();
    push(2, 0, 0, 32'h4, 4'hF, 32'h0);
    load(2);
    for (int n = 0; n < 20 && wt[2] != 2; n++) step();
    chk("stall_cnt", 64'(wt[2]), 64'(2));
    do_reset(1);
    run();
    for (int k = 0; k < NI; k++)
      for (int n = 0; n < 300; n++) begin
        logic [31:0] a;
        a = ($urandom_range(0, 5) == 0 ? ($urandom & 32'hFFFFF000) : 32'h0) | 32'($urandom_range(0, 15) * 4) | 32'($urandom_range(0, 3));
        push(k, $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), a, 4'($urandom), $urandom);
      end
    run();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
